rs_issue_select: RTL
====================

Name: rs_issue_select

Overview:
Issue-side counterpart to the reservation-station dispatch path. Dispatch writes entries and raises per-entry ready requests (`reqs`); this block picks one ready entry per cycle and holds it in an issue register until the functional unit accepts it. It also tells the RS which entry to deallocate, and later broadcasts a wakeup so dependents can clear their dependency-mask bits. Single FU port; one instance per FU.

Parameters:
- RS_ENTRIES, 8, number of RS entries (≥2; power of two not required).
- FU_LATENCY, 2, cycles from FU accept to wakeup broadcast (≥1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqs  in  RS_ENTRIES  per-entry "operands ready" request from RS.
- flush  in  1  synchronous pipeline flush (mispredict/exception).
- fu_ready  in  1  FU can accept the issued entry this cycle.
- grant_oh  out  RS_ENTRIES  one-hot; RS deallocates this entry at the same clock edge.
- issue_valid  out  1  issue register holds a valid entry.
- issue_idx  out  $clog2(RS_ENTRIES)  entry index held in the issue register.
- wakeup_valid  out  1  one-cycle wakeup pulse.
- wakeup_oh  out  RS_ENTRIES  one-hot entry being woken; all zero when wakeup_valid=0.

Behaviour:
- Reset (rst_n=0, asynchronous): issue_valid=0, issue_idx=0, wakeup_valid=0, wakeup_oh=0, rr_ptr=0, wakeup pipeline cleared. grant_oh=0 while in reset.
- Eligible set: reqs & ~(issue_valid ? onehot(issue_idx) : 0). The held entry is never granted twice.
- fire = issue_valid & fu_ready.
- load = ~flush & (|eligible) & (~issue_valid | fu_ready).
- Arbitration is round-robin, combinational:
  - Search starts at rr_ptr, ascending, wrapping at RS_ENTRIES-1 → 0.
  - The winner's one-hot drives grant_oh only when load=1; otherwise grant_oh=0.
- On load: issue_idx ← winner, issue_valid ← 1, rr_ptr ← (winner+1) mod RS_ENTRIES. Latency from a req rising to issue_valid is 1 cycle.
- On fire without load: issue_valid ← 0.
- Simultaneous fire and load: the new entry replaces the old one back-to-back, giving a sustained throughput of 1 issue/cycle.
- Stall (issue_valid & ~fu_ready): issue_idx held stable, grant_oh=0, rr_ptr unchanged.
- Wakeup pipeline:
  - FU_LATENCY-deep shift register of {valid, idx}; stage 0 is loaded with {fire, issue_idx}.
  - The last stage drives wakeup_valid/wakeup_oh, so wakeup appears exactly FU_LATENCY cycles after the fire edge.
  - The pipeline advances every cycle regardless of fu_ready.
- Flush (priority over everything else):
  - Next cycle: issue_valid=0, all wakeup stages invalid, rr_ptr=0.
  - In the flush cycle itself: grant_oh=0, and fire is ignored (no wakeup scheduled).
- reqs with no bits set: no grant, issue register drains normally.
- rst_n deasserted mid-stall: the entry is dropped; the RS is reset by the same rst_n.

Decomposition:
- CORE_PKG: RS_ENTRIES, RS_IDX_W = $clog2(RS_ENTRIES), and typedef rs_idx_t = logic [RS_IDX_W-1:0].
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N], ptr.
  - Outputs gnt_oh[N], gnt_idx, any.
  - Purely combinational, reusable for other select logic.
- Top-level holds rr_ptr, the issue register and the wakeup pipeline.

Test Plan:
- Single request: reqs=8'b0000_0100, fu_ready=1 → grant_oh=8'h04 for 1 cycle; issue_valid=1, issue_idx=2 next cycle; with FU_LATENCY=2, wakeup_oh=8'h04 two cycles after fire.
- Round-robin: reqs=8'hFF held with fu_ready=1 and grants dropping entries → issue_idx sequence 0,1,2,…,7,0 on consecutive cycles, one grant per cycle.
- Back-pressure: issue idx 3, then fu_ready=0 for 4 cycles with reqs=8'h30 → issue_idx stays 3 and grant_oh=0 throughout; on fu_ready=1, grant_oh=8'h10 and issue_idx=4 next cycle.
- Wrap pointer: rr_ptr=7 (after granting 6), reqs=8'h41 → winner 0, then 6.
- Flush: issue_valid=1 with two wakeups in flight, pulse flush → next cycle issue_valid=0, no wakeup_valid for FU_LATENCY+2 cycles, grant_oh=0 in the flush cycle; next grant starts from index 0.
- Async reset: assert rst_n=0 between clock edges while issue_valid=1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rs_issue_select_pkg.sv
// Shared sizing, index type and wrap-around helpers for the RS issue-select slice.
package rs_issue_select_pkg;

  localparam int RS_ENTRIES     = 8;
  localparam int RS_IDX_W       = $clog2(RS_ENTRIES);
  localparam int FU_LATENCY_DEF = 2;

  typedef logic [RS_IDX_W-1:0] rs_idx_t;

  // Modular add for indices already below n; avoids a general modulo operator.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) begin
      s = s - n;
    end else begin
      s = s;
    end
    return s;
  endfunction

endpackage

// File: rtl/rs_issue_select_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, ascending with wrap.
module rs_issue_select_rr_arbiter
  import rs_issue_select_pkg::*;
#(
  parameter int N = RS_ENTRIES
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_oh,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int W = $clog2(N);

  logic [W-1:0] cand_s;

  // Rotating priority scan; the first hit from ptr upward wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = W'(wrap_add(int'(ptr), i, N));
      if (!any && req[cand_s]) begin
        any     = 1'b1;
        gnt_idx = cand_s;
      end else begin
        any = any;
      end
    end
    if (any) begin
      gnt_oh[gnt_idx] = 1'b1;
    end else begin
      gnt_oh = '0;
    end
  end

endmodule

// File: rtl/rs_issue_select.sv
// Single-FU issue select: round-robin pick from ready RS entries, issue register
// with back-pressure, and a fixed-latency wakeup broadcast pipeline.
module rs_issue_select #(
  parameter int RS_ENTRIES = rs_issue_select_pkg::RS_ENTRIES,
  parameter int FU_LATENCY = rs_issue_select_pkg::FU_LATENCY_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RS_ENTRIES-1:0]         reqs,
  input  logic                          flush,
  input  logic                          fu_ready,
  output logic [RS_ENTRIES-1:0]         grant_oh,
  output logic                          issue_valid,
  output logic [$clog2(RS_ENTRIES)-1:0] issue_idx,
  output logic                          wakeup_valid,
  output logic [RS_ENTRIES-1:0]         wakeup_oh
);

  import rs_issue_select_pkg::*;

  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic                  issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]      issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [FU_LATENCY-1:0] wv_q, wv_d;
  logic [IDX_W-1:0]      wi_q [FU_LATENCY];
  logic [IDX_W-1:0]      wi_d [FU_LATENCY];

  logic [RS_ENTRIES-1:0] held_oh_s, eligible_s, win_oh_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic                  win_any_s, fire_s, load_s;

  // The entry sitting in the issue register must not be picked again.
  always_comb begin
    held_oh_s = '0;
    if (issue_valid_q) begin
      held_oh_s[issue_idx_q] = 1'b1;
    end else begin
      held_oh_s = '0;
    end
  end

  assign eligible_s = reqs & ~held_oh_s;

  rs_issue_select_rr_arbiter #(.N(RS_ENTRIES)) u_arb (
    .req     (eligible_s),
    .ptr     (rr_ptr_q),
    .gnt_oh  (win_oh_s),
    .gnt_idx (win_idx_s),
    .any     (win_any_s)
  );

  assign fire_s = issue_valid_q & fu_ready;
  assign load_s = ~flush & win_any_s & (~issue_valid_q | fu_ready);

  // Grant is combinational so the RS frees the entry on the same edge it is loaded here.
  always_comb begin
    if (load_s && rst_n) begin
      grant_oh = win_oh_s;
    end else begin
      grant_oh = '0;
    end
  end

  // Issue register and pointer next state; flush dominates, then load, then drain on fire.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_idx_d   = issue_idx_q;
    rr_ptr_d      = rr_ptr_q;
    if (flush) begin
      issue_valid_d = 1'b0;
      rr_ptr_d      = '0;
    end else if (load_s) begin
      issue_valid_d = 1'b1;
      issue_idx_d   = win_idx_s;
      rr_ptr_d      = IDX_W'(wrap_add(int'(win_idx_s), 1, RS_ENTRIES));
    end else if (fire_s) begin
      issue_valid_d = 1'b0;
    end else begin
      issue_valid_d = issue_valid_q;
    end
  end

  // Wakeup shift register advances every cycle; a flush empties it and drops this cycle's fire.
  always_comb begin
    wv_d = '0;
    for (int s = 0; s < FU_LATENCY; s++) begin
      wi_d[s] = wi_q[s];
    end
    if (flush) begin
      wv_d = '0;
    end else begin
      wv_d[0] = fire_s;
      wi_d[0] = issue_idx_q;
      for (int s = 1; s < FU_LATENCY; s++) begin
        wv_d[s] = wv_q[s-1];
        wi_d[s] = wi_q[s-1];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      rr_ptr_q      <= '0;
      wv_q          <= '0;
      for (int s = 0; s < FU_LATENCY; s++) begin
        wi_q[s] <= '0;
      end
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      wv_q          <= wv_d;
      for (int s = 0; s < FU_LATENCY; s++) begin
        wi_q[s] <= wi_d[s];
      end
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_idx    = issue_idx_q;
  assign wakeup_valid = wv_q[FU_LATENCY-1];

  // Decode the last wakeup stage; all-zero when it is empty.
  always_comb begin
    wakeup_oh = '0;
    if (wv_q[FU_LATENCY-1]) begin
      wakeup_oh[wi_q[FU_LATENCY-1]] = 1'b1;
    end else begin
      wakeup_oh = '0;
    end
  end

endmodule
